// File: rtl/softmax_classifier.sv
// Serial top-1/top-2 scanner over a softmax vector: reports the winning class,
// its confidence, the top-1/top-2 margin and an early-exit flag.
module softmax_classifier #(
  parameter int DENSE_KSIZE = 10,
  parameter int BIT_SOFTMAX = 16,
  parameter int BIT_CLASS   = $clog2(DENSE_KSIZE)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [BIT_SOFTMAX*DENSE_KSIZE-1:0] y,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BIT_SOFTMAX-1:0]           conf_thresh,
  input  logic [BIT_SOFTMAX-1:0]           margin_thresh,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BIT_CLASS-1:0]             class_id,
  output logic [BIT_SOFTMAX-1:0]           confidence,
  output logic [BIT_SOFTMAX-1:0]           margin,
  output logic                             early_exit
);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, HOLD} state_t;

  state_t                                  r_state;
  logic [DENSE_KSIZE-1:0][BIT_SOFTMAX-1:0] r_vec;
  logic [BIT_CLASS-1:0]                    r_cnt;
  logic [BIT_CLASS-1:0]                    r_idx;
  logic [BIT_SOFTMAX-1:0]                  r_top1;
  logic [BIT_SOFTMAX-1:0]                  r_top2;
  logic [BIT_SOFTMAX-1:0]                  r_conf_th;
  logic [BIT_SOFTMAX-1:0]                  r_marg_th;

  logic [BIT_SOFTMAX-1:0] w_elem;
  logic [BIT_SOFTMAX-1:0] w_diff;
  logic                   w_last;

  assign w_elem = r_vec[r_cnt];
  // top2 never exceeds top1, so this difference cannot wrap
  assign w_diff = r_top1 - r_top2;
  assign w_last = (r_cnt == BIT_CLASS'(DENSE_KSIZE - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_top1     <= '0;
      r_top2     <= '0;
      r_conf_th  <= '0;
      r_marg_th  <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      class_id   <= '0;
      confidence <= '0;
      margin     <= '0;
      early_exit <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            r_vec     <= y;
            r_conf_th <= conf_thresh;
            r_marg_th <= margin_thresh;
            r_top1    <= '0;
            r_top2    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b0;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          // strict compares: lowest index keeps top1 on ties, the tie lands in top2
          if (w_elem > r_top1) begin
            r_top2 <= r_top1;
            r_top1 <= w_elem;
            r_idx  <= r_cnt;
          end else if (w_elem > r_top2) begin
            r_top2 <= w_elem;
          end
          if (w_last) r_state <= DECIDE;
          else        r_cnt   <= r_cnt + 1'b1;
        end
        DECIDE: begin
          class_id   <= r_idx;
          confidence <= r_top1;
          margin     <= w_diff;
          early_exit <= (r_top1 >= r_conf_th) && (w_diff >= r_marg_th);
          out_valid  <= 1'b1;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_classifier.sv
// Directed bench for softmax_classifier: scoreboard of expected results pushed at
// accept and popped when out_valid appears.
module tb_softmax_classifier;
  localparam int K = 10;
  localparam int W = 16;
  localparam int C = $clog2(K);

  typedef logic [K-1:0][W-1:0] vec_t;
  typedef struct {
    logic [C-1:0] cls;
    logic [W-1:0] conf;
    logic [W-1:0] marg;
    logic         ee;
    int           t_acc;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [W*K-1:0] y = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   conf_thresh = '0;
  logic [W-1:0]   margin_thresh = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [C-1:0]   class_id;
  logic [W-1:0]   confidence;
  logic [W-1:0]   margin;
  logic           early_exit;

  softmax_classifier #(.DENSE_KSIZE(K), .BIT_SOFTMAX(W)) dut (
    .clock(clock), .reset(reset), .y(y), .in_valid(in_valid), .in_ready(in_ready),
    .conf_thresh(conf_thresh), .margin_thresh(margin_thresh),
    .out_valid(out_valid), .out_ready(out_ready), .class_id(class_id),
    .confidence(confidence), .margin(margin), .early_exit(early_exit)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   last_wait = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t fill(input logic [W-1:0] val);
    vec_t v;
    for (int i = 0; i < K; i++) v[i] = val;
    return v;
  endfunction

  // Reference: top1 = max with first index, top2 = max over all other positions
  function automatic exp_t model(input vec_t v, input logic [W-1:0] ct, input logic [W-1:0] mt);
    exp_t e;
    logic [W-1:0] t1, t2;
    int ix;
    t1 = '0; ix = 0; t2 = '0;
    for (int i = 0; i < K; i++) if (v[i] > t1) begin t1 = v[i]; ix = i; end
    for (int i = 0; i < K; i++) if (i != ix && v[i] > t2) t2 = v[i];
    e.cls = C'(ix); e.conf = t1; e.marg = t1 - t2;
    e.ee = (t1 >= ct) && ((t1 - t2) >= mt);
    e.t_acc = 0;
    return e;
  endfunction

  task automatic accept(input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    last_wait = n;
    tick;
    e.t_acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic [W-1:0] ct, input logic [W-1:0] mt);
    y = v; conf_thresh = ct; margin_thresh = mt; in_valid = 1'b1;
    accept(model(v, ct, mt));
  endtask

  task automatic send_exp(input vec_t v, input logic [W-1:0] ct, input logic [W-1:0] mt,
                          input int cls, input logic [W-1:0] conf, input logic [W-1:0] marg,
                          input logic ee);
    exp_t e;
    e.cls = C'(cls); e.conf = conf; e.marg = marg; e.ee = ee; e.t_acc = 0;
    y = v; conf_thresh = ct; margin_thresh = mt; in_valid = 1'b1;
    accept(e);
  endtask

  task automatic cmp_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, cyc - e.t_acc, K + 1);
      chk({tag, "_class"}, 32'(class_id), 32'(e.cls));
      chk({tag, "_conf"}, 32'(confidence), 32'(e.conf));
      chk({tag, "_margin"}, 32'(margin), 32'(e.marg));
      chk({tag, "_early"}, 32'(early_exit), 32'(e.ee));
    end
  endtask

  // Wait for a result, compare it, optionally stall, then release it
  task automatic consume(input string tag, input int hold, input bit scramble);
    int n;
    logic [C-1:0] c0;
    logic [W-1:0] f0, m0;
    logic e0;
    vec_t r;
    n = 0;
    while (!out_valid && n < 40) begin
      if (scramble) begin
        for (int i = 0; i < K; i++) r[i] = W'($urandom);
        y = r; conf_thresh = W'($urandom); margin_thresh = W'($urandom);
      end
      tick; n++;
    end
    chk({tag, "_ovalid"}, {31'd0, out_valid}, 32'd1);
    cmp_pop(tag);
    c0 = class_id; f0 = confidence; m0 = margin; e0 = early_exit;
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      for (int j = 0; j < K; j++) r[j] = W'($urandom);
      y = r;
      tick;
      chk({tag, "_hold_ovalid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_iready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_fields"}, {c0, f0, m0, e0}, {class_id, confidence, margin, early_exit});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk({tag, "_release_ovalid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_release_iready"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t bv[3];
    int acc_t[$];
    int bi, got;
    bit acc, prev_ov, seen;
    exp_t e;

    // Reset state
    tick; tick;
    chk("rst_iready", {31'd0, in_ready}, 32'd0);
    chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("rst_fields", {class_id, confidence, margin, early_exit}, '0);
    reset = 1'b1;
    #1;
    chk("rel_iready_before_edge", {31'd0, in_ready}, 32'd0);
    tick;
    chk("rel_iready_after_edge", {31'd0, in_ready}, 32'd1);

    // Basic: element 7 dominates
    v = fill(16'h0100); v[7] = 16'hC000;
    send_exp(v, 16'h8000, 16'h4000, 7, 16'hC000, 16'hBF00, 1'b1);
    consume("basic", 0, 1'b0);

    // Ties: lowest index wins, margin 0
    v = fill(16'h1000); v[2] = 16'h6000; v[5] = 16'h6000;
    send_exp(v, 16'h0000, 16'h0001, 2, 16'h6000, 16'h0000, 1'b0);
    consume("tie_m1", 0, 1'b0);
    send_exp(v, 16'h6000, 16'h0000, 2, 16'h6000, 16'h0000, 1'b1);
    consume("tie_m0", 0, 1'b0);

    // Boundaries: all-zero and maximum thresholds
    v = fill(16'h0000);
    send_exp(v, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1);
    consume("zero_th0", 0, 1'b0);
    send_exp(v, 16'h0001, 16'h0000, 0, 16'h0000, 16'h0000, 1'b0);
    consume("zero_th1", 0, 1'b0);
    v[3] = 16'hFFFF;
    send_exp(v, 16'hFFFF, 16'hFFFF, 3, 16'hFFFF, 16'hFFFF, 1'b1);
    consume("max_eq", 0, 1'b0);
    v[3] = 16'hFFFE;
    send_exp(v, 16'hFFFF, 16'h0000, 3, 16'hFFFE, 16'hFFFE, 1'b0);
    consume("max_below", 0, 1'b0);

    // Backpressure, then next vector accepted on the following edge
    v = fill(16'h0200); v[0] = 16'h0300; v[8] = 16'h7000;
    send(v, 16'h7000, 16'h6E00);
    consume("bp", 20, 1'b0);
    v = fill(16'h0050); v[4] = 16'h0060; v[1] = 16'h0055;
    send(v, 16'h0010, 16'h0010);
    chk("bp_accept_next", last_wait, 0);
    consume("bp_next", 0, 1'b0);

    // Inputs change every cycle during SCAN
    v = fill(16'h2222); v[6] = 16'h9999; v[9] = 16'h8888;
    send(v, 16'h9000, 16'h1000);
    consume("scramble", 0, 1'b1);

    // Reset mid-SCAN
    v = fill(16'h1111); v[1] = 16'hEEEE;
    send(v, 16'h0000, 16'h0000);
    tick; tick; tick; tick;
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("midrst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("midrst_iready", {31'd0, in_ready}, 32'd0);
    chk("midrst_fields", {class_id, confidence, margin, early_exit}, '0);
    tick; tick;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < K + 5; i++) begin tick; if (out_valid) seen = 1'b1; end
    chk("midrst_no_ovalid", {31'd0, seen}, 32'd0);
    chk("midrst_iready_back", {31'd0, in_ready}, 32'd1);
    v = fill(16'h4000); v[9] = 16'hFFFF;
    send_exp(v, 16'h0000, 16'h0000, 9, 16'hFFFF, 16'hBFFF, 1'b1);
    consume("post_rst", 0, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    bv[0] = fill(16'h0100); bv[0][3] = 16'h5000; bv[0][4] = 16'h4000;
    bv[1] = fill(16'h0A00); bv[1][0] = 16'hA000;
    bv[2] = fill(16'h3000); bv[2][9] = 16'h3001;
    conf_thresh = 16'h4000; margin_thresh = 16'h0800;
    out_ready = 1'b1;
    y = bv[0]; in_valid = 1'b1;
    bi = 0; got = 0; prev_ov = 1'b0;
    for (int n = 0; n < 200 && got < 3; n++) begin
      acc = in_valid && in_ready;
      if (acc) begin
        e = model(bv[bi], conf_thresh, margin_thresh);
        e.t_acc = cyc + 1;
        sb.push_back(e);
      end
      tick;
      if (acc) begin
        acc_t.push_back(cyc);
        bi++;
        if (bi < 3) y = bv[bi];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        chk("b2b_single_cycle", {31'd0, prev_ov}, 32'd0);
        cmp_pop("b2b");
        got++;
      end
      prev_ov = out_valid;
    end
    out_ready = 1'b0;
    chk("b2b_count", got, 3);
    if (acc_t.size() == 3) begin
      chk("b2b_spacing01", acc_t[1] - acc_t[0], K + 3);
      chk("b2b_spacing12", acc_t[2] - acc_t[1], K + 3);
    end else begin
      chk("b2b_accepts", acc_t.size(), 3);
    end
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
